// File: rtl/jtcontra_gfx_lineout.sv
// jtcontra_gfx_lineout
// Double-banked line buffers for the chr (fixed) and scr (scroll) tile layers.
// The tilemap writer fills the bank selected by the line input through port A.
// The reader scans the other bank once per active line through port B, and
// every location it reads is cleared one clk later.
// The two layers are mixed into a single 9-bit pixel.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   pxl_cen    pixel clock enable (never on two consecutive clks)
//   LHBL       horizontal blank, active low
//   line       bank currently owned by the writer
//   chr_we     chr buffer write strobe
//   scr_we     scr buffer write strobe
//   line_addr  write address {bank, x[8:0]}
//   line_din   write data {scrwin, pal[3:0], color[3:0]}
//   pxl        mixed pixel {layer (1 = chr), pal[3:0], color[3:0]}
//   init_busy  high while the post-reset clear sweep runs
module jtcontra_gfx_lineout #(
  parameter int HLEN = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       line,
  input  logic       chr_we,
  input  logic       scr_we,
  input  logic [9:0] line_addr,
  input  logic [8:0] line_din,
  output logic [8:0] pxl,
  output logic       init_busy
);

  localparam logic [9:0] HLEN_X = 10'(HLEN);

  logic [8:0] chr_mem [0:1023];
  logic [8:0] scr_mem [0:1023];

  logic [9:0] init_addr;
  logic       lhbl_l;
  logic       line_l;
  logic [8:0] rd_x;
  logic       rd_valid;
  logic       clr_pend;
  logic [9:0] clr_addr;
  logic [8:0] chr_q;
  logic [8:0] scr_q;

  logic       lhbl_rise;
  logic       rd_go;
  logic [9:0] rd_addr;
  logic       chr_sel;
  logic [8:0] pxl_sel;

  // The line-start clk only restarts the scan; it never reads, even if
  // pxl_cen happens to coincide with it.
  always_comb begin
    lhbl_rise = LHBL & ~lhbl_l;
    rd_go     = pxl_cen & LHBL & ~lhbl_rise & ~init_busy & ({1'b0, rd_x} < HLEN_X);
    rd_addr   = {~line_l, rd_x};
    // A scroll pixel with its window bit set and a visible colour sits in
    // front of the fixed layer; otherwise an opaque chr pixel wins. When both
    // layers are transparent the scr entry goes out so its palette can still
    // pick the backdrop.
    chr_sel   = (chr_q[3:0] != 4'd0) && !(scr_q[8] && (scr_q[3:0] != 4'd0));
    pxl_sel   = chr_sel ? {1'b1, chr_q[7:0]} : {1'b0, scr_q[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_busy <= 1'b1;
      init_addr <= 10'd0;
      lhbl_l    <= 1'b0;
      line_l    <= 1'b0;
      rd_x      <= 9'd0;
      rd_valid  <= 1'b0;
      clr_pend  <= 1'b0;
      clr_addr  <= 10'd0;
      pxl       <= 9'd0;
    end else begin
      lhbl_l <= LHBL;
      if (init_busy) begin
        init_addr <= init_addr + 10'd1;
        if (init_addr == 10'd1023) init_busy <= 1'b0;
      end
      if (lhbl_rise) begin
        rd_x   <= 9'd0;
        line_l <= line;
      end else if (rd_go) begin
        rd_x <= rd_x + 9'd1;
      end
      clr_pend <= rd_go;
      if (rd_go) clr_addr <= rd_addr;
      if (pxl_cen) rd_valid <= rd_go;
      if (init_busy)    pxl <= 9'd0;
      else if (pxl_cen) pxl <= rd_valid ? pxl_sel : 9'd0;
    end
  end

  // The port-A write comes after the erase-on-read clear, so it wins when
  // both hit the same address on the same clk.
  always_ff @(posedge clk) begin
    if (init_busy && !rst) begin
      chr_mem[init_addr] <= 9'd0;
      scr_mem[init_addr] <= 9'd0;
    end else begin
      if (clr_pend) begin
        chr_mem[clr_addr] <= 9'd0;
        scr_mem[clr_addr] <= 9'd0;
      end
      if (chr_we && !init_busy) chr_mem[line_addr] <= line_din;
      if (scr_we && !init_busy) scr_mem[line_addr] <= line_din;
    end
    if (rd_go) begin
      chr_q <= chr_mem[rd_addr];
      scr_q <= scr_mem[rd_addr];
    end
  end

endmodule

// File: doc/jtcontra_gfx_lineout.md
JTCONTRA_GFX_LINEOUT -- requirements
Module: jtcontra_gfx_lineout

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have port: pxl_cen  in  1  pixel clock enable; asserted at most one clk in every two.
REQ-004 SHALL have port: LHBL  in  1  horizontal blank, active-low (high = active line).
REQ-005 SHALL have port: line  in  1  bank currently being written by the tilemap writer.
REQ-006 SHALL have port: chr_we  in  1  write strobe, chr (fixed) layer buffer.
REQ-007 SHALL have port: scr_we  in  1  write strobe, scr (scroll) layer buffer.
REQ-008 SHALL have port: line_addr  in  10  write address {bank, 9-bit x}.
REQ-009 SHALL have port: line_din  in  9  write data {scrwin, pal[3:0], color[3:0]}.
REQ-010 SHALL have port: pxl  out  9  {layer (1 = chr), pal[3:0], color[3:0]}.
REQ-011 SHALL have port: init_busy  out  1  high while post-reset clear sweep runs.
REQ-012 SHALL have parameter: HLEN, default 320, number of pixels read per line.

Function
REQ-013 SHALL hold two 1024x9 buffers (chr, scr), each dual-port: port A write-only (writer side), port B read-then-clear (reader side).
REQ-014 SHALL write line_din to chr buffer at line_addr on any clk with chr_we=1; same for scr with scr_we=1; when init_busy=0 only.
REQ-015 SHALL read from bank ~line only; bank sampled at LHBL rising edge and held for the whole line.
REQ-016 SHALL detect LHBL rising edge via a registered copy of LHBL; on that clk rd_x resets to 0.
REQ-017 SHALL, on each pxl_cen with LHBL=1 and rd_x<HLEN, present {~line_latched, rd_x} on port B and increment rd_x (9-bit).
REQ-018 SHALL stop incrementing at rd_x=HLEN; further reads suppressed until next LHBL rising edge.
REQ-019 SHALL, one clk after each read, write 9'd0 to the same port-B address of both buffers (erase-on-read).
REQ-020 SHALL, if port A and port-B clear target the same address on the same clk, let port A write win.
REQ-021 SHALL select chr pixel when chr color!=0 and NOT (scr scrwin=1 and scr color!=0); else select scr pixel.
REQ-022 SHALL register selection into pxl on the pxl_cen after the read: latency exactly one pxl_cen period.
REQ-023 SHALL output pxl=0 on the pxl_cen following any pxl_cen with LHBL=0 or rd_x>=HLEN.
REQ-024 SHALL, on both layers having color 0, output scr pixel with layer bit 0 (palette kept for backdrop).

Reset
REQ-025 SHALL on rst: pxl=0, rd_x=0, init_busy=1, latched bank=0, clear-pending flag=0.
REQ-026 SHALL after rst release sweep addresses 0..1023, writing 0 to both buffers one address per clk (1024 clks).
REQ-027 SHALL deassert init_busy on the clk after address 1023 is cleared; pxl forced 0 while init_busy=1.
REQ-028 SHALL restart the sweep from address 0 if rst asserts mid-sweep or mid-line.

Verification
REQ-029 Reset 1 clk, release -> init_busy=1 for exactly 1024 clks; any addr read afterwards = 0.
REQ-030 line=0, scr_we writes 9'h0A5 at addr 0x005, toggle line=1, LHBL rise -> 6th pxl after edge = 9'h0A5, next line same x reads 0.
REQ-031 chr 9'h013 and scr 9'h025 at same x -> pxl=9'h113; scr 9'h125 (scrwin) -> pxl=9'h025.
REQ-032 chr color 0, scr 9'h030 -> pxl=9'h030; both 0 -> pxl=0.
REQ-033 LHBL held high 400 pxl_cen -> exactly 320 reads, pxl=0 from 321st period on.
REQ-034 rst asserted at rd_x=100 -> pxl=0 next clk, init_busy=1, sweep restarts at 0.
